// File: rtl/bec_ladder_sequencer_pkg.sv
// Shared types and constants for the BEC ladder run sequencer.
package bec_ladder_sequencer_pkg;

  localparam int DEF_WIDTH   = 163;
  localparam int DEF_TIMEOUT = 2000;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_UPLOAD   = 3'd1,
    S_PROC     = 3'd2,
    S_DOWNLOAD = 3'd3,
    S_DONE     = 3'd4,
    S_ERROR    = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_UNDERRUN = 2'b10;
  localparam logic [1:0] ERR_OVERRUN  = 2'b11;

  function automatic logic is_busy(input state_e s);
    return (s == S_UPLOAD) || (s == S_PROC) || (s == S_DOWNLOAD);
  endfunction

endpackage

// File: rtl/bec_ladder_sequencer_if.sv
// Control, core-handshake and wrapper-enable signals of the ladder sequencer.
interface bec_ladder_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic             ack;
  logic [3:0]       becStatus;
  logic             next_key;
  logic             slv_done;
  logic             load_data;
  logic             op_shift;
  logic             master_ena_proc;
  logic             key_shift;
  logic             capture_en;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] bit_cnt_o;

  modport master (
    output start, abort, ack, becStatus, next_key, slv_done,
    input  load_data, op_shift, master_ena_proc, key_shift, capture_en,
    input  busy, done, err, err_code, state_o, bit_cnt_o
  );

  modport slave (
    input  start, abort, ack, becStatus, next_key, slv_done,
    output load_data, op_shift, master_ena_proc, key_shift, capture_en,
    output busy, done, err, err_code, state_o, bit_cnt_o
  );
endinterface

// File: rtl/bec_ladder_sequencer_watchdog.sv
// No-progress watchdog: counts busy cycles without progress, flags the cycle that would reach TIMEOUT.
module bec_ladder_sequencer_watchdog #(
  parameter int TIMEOUT = 2000,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CAP   = TO_W'(TIMEOUT);

  logic [TO_W-1:0] cnt;

  // Stall counter, saturating at TIMEOUT
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || !run) begin
      cnt <= '0;
    end else if (cnt < CAP) begin
      cnt <= cnt + TO_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  // Fires in the TIMEOUT-th consecutive stalled cycle so ERROR follows one clock later
  assign expired = run && !clear && (cnt >= LIMIT);

endmodule

// File: rtl/bec_ladder_sequencer.sv
// Sequences one BEC ladder run: operand upload, key-driven processing, result download.
module bec_ladder_sequencer
  import bec_ladder_sequencer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = $clog2(WIDTH),
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input logic                   wb_clk_i,
  input logic                   wb_rst_i,
  bec_ladder_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] keys_seen;
  logic [1:0]       err_code;
  logic [1:0]       code_next;
  logic             load_data;
  logic             op_shift;
  logic             ena_proc;
  logic             key_shift;
  logic             capture_en;
  logic             progress;
  logic             wd_expired;
  logic             unused_status;

  assign unused_status = ^{bus.becStatus[3], bus.becStatus[1]};

  // Progress is derived from inputs and state only, so the watchdog never loops through the FSM
  assign progress = bus.abort
                  || ((state == S_UPLOAD)   && bus.becStatus[2])
                  || ((state == S_PROC)     && (bus.next_key || bus.slv_done))
                  || ((state == S_DOWNLOAD) && bus.becStatus[0]);

  bec_ladder_sequencer_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (progress),
    .run     (is_busy(state)),
    .expired (wd_expired)
  );

  // State, bit counter and error code registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_next;
      bit_cnt  <= cnt_next;
      err_code <= code_next;
    end
  end

  // Next-state, counter update and enable decode
  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    code_next  = err_code;
    keys_seen  = bit_cnt;
    load_data  = 1'b0;
    op_shift   = 1'b0;
    ena_proc   = 1'b0;
    key_shift  = 1'b0;
    capture_en = 1'b0;
    if (bus.abort) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      code_next  = ERR_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_next  = '0;
          code_next = ERR_NONE;
          if (bus.start) begin
            state_next = S_UPLOAD;
          end else begin
            state_next = S_IDLE;
          end
        end
        S_UPLOAD: begin
          load_data = bus.becStatus[2];
          op_shift  = bus.becStatus[2];
          if (bus.becStatus[2]) begin
            if (bit_cnt == LAST) begin
              state_next = S_PROC;
              cnt_next   = '0;
            end else begin
              cnt_next = bit_cnt + CNT_W'(1);
            end
          end else if (wd_expired) begin
            state_next = S_ERROR;
            code_next  = ERR_TIMEOUT;
          end else begin
            cnt_next = bit_cnt;
          end
        end
        S_PROC: begin
          ena_proc = 1'b1;
          if (bus.next_key && (bit_cnt == FULL)) begin
            // The surplus key bit is never shifted into the wrapper
            key_shift  = 1'b0;
            state_next = S_ERROR;
            code_next  = ERR_OVERRUN;
          end else begin
            key_shift = bus.next_key;
            if (bus.next_key) begin
              keys_seen = bit_cnt + CNT_W'(1);
            end else begin
              keys_seen = bit_cnt;
            end
            if (bus.slv_done) begin
              if (keys_seen == FULL) begin
                state_next = S_DOWNLOAD;
                cnt_next   = '0;
              end else begin
                state_next = S_ERROR;
                code_next  = ERR_UNDERRUN;
                cnt_next   = keys_seen;
              end
            end else if (bus.next_key) begin
              cnt_next = keys_seen;
            end else if (wd_expired) begin
              state_next = S_ERROR;
              code_next  = ERR_TIMEOUT;
            end else begin
              cnt_next = bit_cnt;
            end
          end
        end
        S_DOWNLOAD: begin
          capture_en = bus.becStatus[0];
          if (bus.becStatus[0]) begin
            if (bit_cnt == LAST) begin
              state_next = S_DONE;
              cnt_next   = FULL;
            end else begin
              cnt_next = bit_cnt + CNT_W'(1);
            end
          end else if (wd_expired) begin
            state_next = S_ERROR;
            code_next  = ERR_TIMEOUT;
          end else begin
            cnt_next = bit_cnt;
          end
        end
        S_DONE: begin
          if (bus.ack) begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end else begin
            state_next = S_DONE;
          end
        end
        S_ERROR: begin
          if (bus.ack) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            code_next  = ERR_NONE;
          end else begin
            state_next = S_ERROR;
          end
        end
        default: begin
          state_next = S_IDLE;
          cnt_next   = '0;
          code_next  = ERR_NONE;
        end
      endcase
    end
  end

  assign bus.load_data       = load_data;
  assign bus.op_shift        = op_shift;
  assign bus.master_ena_proc = ena_proc;
  assign bus.key_shift       = key_shift;
  assign bus.capture_en      = capture_en;
  assign bus.busy            = is_busy(state);
  assign bus.done            = (state == S_DONE);
  assign bus.err             = (state == S_ERROR);
  assign bus.err_code        = err_code;
  assign bus.state_o         = state;
  assign bus.bit_cnt_o       = bit_cnt;

endmodule

// File: tb/tb_bec_ladder_sequencer.sv
// Randomized directed bench for bec_ladder_sequencer against a count-based run model.
module tb_bec_ladder_sequencer;

  localparam int WIDTH   = 163;
  localparam int TIMEOUT = 2000;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  bec_ladder_sequencer_if #(.CNT_W(8)) bus ();

  bec_ladder_sequencer #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.ack       = 1'b0;
    bus.becStatus = 4'd0;
    bus.next_key  = 1'b0;
    bus.slv_done  = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk(tag, 32'({bus.load_data, bus.op_shift, bus.master_ena_proc, bus.key_shift,
                  bus.capture_en, bus.busy, bus.done, bus.err, bus.err_code,
                  bus.state_o, bus.bit_cnt_o}), 32'd0);
  endtask

  // Model of a run outcome: final state and code from the number of keys and whether slv_done was sent
  function automatic int exp_state(input int nkeys, input bit send_done);
    if (nkeys > WIDTH) return 5;
    if (send_done) return (nkeys == WIDTH) ? 3 : 5;
    return 2;
  endfunction

  function automatic int exp_code(input int nkeys, input bit send_done);
    if (nkeys > WIDTH) return 3;
    if (send_done && nkeys < WIDTH) return 2;
    return 0;
  endfunction

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_state", 32'(bus.state_o), 32'd1);
    chk("start_cnt", 32'(bus.bit_cnt_o), 32'd0);
  endtask

  task automatic run_upload(input int stall_pct, input int stall_at, input int stall_len);
    int shifts  = 0;
    int seen    = 0;
    int stalled = 0;
    int cyc     = 0;
    while (shifts < WIDTH && cyc < 4000) begin
      logic b2;
      if (shifts == stall_at && stalled < stall_len) begin
        b2 = 1'b0;
        stalled++;
      end else begin
        b2 = ($urandom_range(99) >= stall_pct);
      end
      bus.becStatus = {1'b0, b2, 2'b00};
      #1;
      chk("upl_op_shift", 32'(bus.op_shift), 32'(b2));
      chk("upl_load_data", 32'(bus.load_data), 32'(b2));
      chk("upl_bit_cnt", 32'(bus.bit_cnt_o), 32'(shifts));
      if (bus.op_shift) seen++;
      tick();
      cyc++;
      if (b2) shifts++;
    end
    bus.becStatus = 4'd0;
    chk("upl_total_shifts", 32'(seen), 32'(WIDTH));
    chk("upl_to_proc", 32'(bus.state_o), 32'd2);
    chk("proc_cnt_zero", 32'(bus.bit_cnt_o), 32'd0);
  endtask

  task automatic run_proc(input int nkeys, input bit send_done, input bit same_cycle);
    int  keys = 0;
    int  seen = 0;
    bit  over = 1'b0;
    for (int k = 0; k < nkeys && !over; k++) begin
      int gap;
      gap = $urandom_range(2);
      for (int g = 0; g < gap; g++) begin
        #1;
        chk("proc_ena_gap", 32'(bus.master_ena_proc), 32'd1);
        chk("proc_keyshift_gap", 32'(bus.key_shift), 32'd0);
        tick();
      end
      bus.next_key = 1'b1;
      if (k == nkeys - 1 && send_done && same_cycle) bus.slv_done = 1'b1;
      #1;
      chk("proc_ena", 32'(bus.master_ena_proc), 32'd1);
      chk("proc_key_shift", 32'(bus.key_shift), (keys < WIDTH) ? 32'd1 : 32'd0);
      if (bus.key_shift) seen++;
      if (keys >= WIDTH) over = 1'b1;
      keys++;
      tick();
      bus.next_key = 1'b0;
      bus.slv_done = 1'b0;
    end
    if (send_done && !same_cycle) begin
      bus.slv_done = 1'b1;
      #1;
      chk("proc_ena_done", 32'(bus.master_ena_proc), 32'd1);
      tick();
      bus.slv_done = 1'b0;
    end
    chk("proc_key_shifts", 32'(seen), 32'((nkeys > WIDTH) ? WIDTH : nkeys));
    chk("proc_state", 32'(bus.state_o), 32'(exp_state(nkeys, send_done)));
    chk("proc_err_code", 32'(bus.err_code), 32'(exp_code(nkeys, send_done)));
  endtask

  task automatic run_download(input int stall_pct, input int stop_at);
    int caps = 0;
    int seen = 0;
    int cyc  = 0;
    while (caps < stop_at && cyc < 4000) begin
      logic b0;
      b0 = ($urandom_range(99) >= stall_pct);
      bus.becStatus = {3'b000, b0};
      #1;
      chk("dl_capture_en", 32'(bus.capture_en), 32'(b0));
      chk("dl_bit_cnt", 32'(bus.bit_cnt_o), 32'(caps));
      chk("dl_no_op_shift", 32'({bus.op_shift, bus.load_data, bus.key_shift}), 32'd0);
      if (bus.capture_en) seen++;
      tick();
      cyc++;
      if (b0) caps++;
    end
    bus.becStatus = 4'd0;
    chk("dl_captures", 32'(seen), 32'(stop_at));
    if (stop_at == WIDTH) begin
      chk("dl_state_done", 32'(bus.state_o), 32'd4);
      chk("dl_flags", 32'({bus.busy, bus.done, bus.err}), 32'b010);
    end else begin
      chk("dl_state_mid", 32'(bus.state_o), 32'd3);
    end
  endtask

  task automatic ack_to_idle();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("ack_idle", 32'(bus.state_o), 32'd0);
    chk("ack_flags", 32'({bus.busy, bus.done, bus.err, bus.err_code, bus.bit_cnt_o}), 32'd0);
  endtask

  task automatic full_run(input int pu, input int pd);
    do_start();
    run_upload(pu, -1, 0);
    run_proc(WIDTH, 1'b1, 1'(($urandom_range(1))));
    run_download(pd, WIDTH);
    ack_to_idle();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    all_zero("reset_outputs");

    // Nominal run, no stalls; start is ignored in DONE
    do_start();
    run_upload(0, -1, 0);
    run_proc(WIDTH, 1'b1, 1'b0);
    run_download(0, WIDTH);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("done_ignores_start", 32'(bus.state_o), 32'd4);
    ack_to_idle();

    // Randomly stalled run
    full_run(30, 40);

    // 50-cycle upload stall at bit 60
    do_start();
    run_upload(0, 60, 50);
    run_proc(WIDTH, 1'b1, 1'b1);
    run_download(10, WIDTH);
    ack_to_idle();

    // Watchdog in PROC
    do_start();
    run_upload(20, -1, 0);
    repeat (TIMEOUT - 1) tick();
    chk("wd_not_early", 32'({bus.state_o, bus.err}), 32'({3'd2, 1'b0}));
    tick();
    chk("wd_err", 32'(bus.err), 32'd1);
    chk("wd_code", 32'(bus.err_code), 32'd1);
    chk("wd_state", 32'(bus.state_o), 32'd5);
    ack_to_idle();

    // Key underrun: no capture afterwards
    do_start();
    run_upload(10, -1, 0);
    run_proc(100, 1'b1, 1'(($urandom_range(1))));
    chk("underrun_err", 32'(bus.err), 32'd1);
    bus.becStatus = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("underrun_no_capture", 32'(bus.capture_en), 32'd0);
      tick();
    end
    bus.becStatus = 4'd0;
    ack_to_idle();

    // Key overrun
    do_start();
    run_upload(10, -1, 0);
    run_proc(WIDTH + 1, 1'b0, 1'b0);
    chk("overrun_err", 32'(bus.err), 32'd1);
    ack_to_idle();

    // Abort mid-download, then start+abort in IDLE, then a full run
    do_start();
    run_upload(0, -1, 0);
    run_proc(WIDTH, 1'b1, 1'b0);
    run_download(25, 80);
    chk("abort_pre_cnt", 32'(bus.bit_cnt_o), 32'd80);
    bus.becStatus = 4'b0001;
    bus.abort     = 1'b1;
    tick();
    idle_inputs();
    #1;
    all_zero("abort_outputs");
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    idle_inputs();
    #1;
    all_zero("start_with_abort");
    full_run(15, 15);

    // Reset mid-download, then a full run
    do_start();
    run_upload(0, -1, 0);
    run_proc(WIDTH, 1'b1, 1'b0);
    run_download(0, 80);
    bus.becStatus = 4'b0001;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    all_zero("reset_mid_dl");
    full_run(25, 25);

    // Random outcome campaign
    for (int r = 0; r < 4; r++) begin
      int sel;
      int nk;
      bit sd;
      sel = $urandom_range(2);
      if (sel == 0) begin
        nk = 1 + $urandom_range(WIDTH - 2);
        sd = 1'b1;
      end else if (sel == 1) begin
        nk = WIDTH;
        sd = 1'b1;
      end else begin
        nk = WIDTH + 1;
        sd = 1'b0;
      end
      do_start();
      run_upload(20, -1, 0);
      run_proc(nk, sd, 1'(($urandom_range(1))));
      if (exp_state(nk, sd) == 3) begin
        run_download(20, WIDTH);
      end
      ack_to_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
